// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 receive path: receiver state
//               encoding, frame geometry, default clock-filter depth and an
//               odd-parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receiver states. The width is explicit so the encoding never depends on
    // the number of states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DPS  = 2'd1,   // data, parity and stop bits
        ST_LOAD = 2'd2
    } ps2_rx_state_t;

    // Frame geometry: start + 8 data + parity + stop.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // Default ps2c glitch-filter depth in clk cycles.
    localparam int FILTER_LEN_DEFAULT = 8;

    // Returns 1 when data + parity bits hold an even number of ones, which
    // is a parity failure under odd parity.
    function automatic logic odd_parity_error(input logic [DATA_BITS:0] bits);
        return ~(^bits);
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_clk_filter
// Description : Glitch filter and falling-edge detector for the PS/2 clock
//               line. The filtered level only changes once FILTER_LEN
//               consecutive samples agree, so short pulses are discarded.
// Ports       : clk         - system clock
//               reset_n     - asynchronous, active-low reset
//               i_ps2c      - raw PS/2 clock line
//               o_fall_edge - one-cycle pulse on a filtered high-to-low edge
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_ps2c,
    output logic o_fall_edge
);

    logic [FILTER_LEN-1:0] r_filter;
    logic                  r_f_ps2c;
    logic                  w_f_ps2c_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filter <= '0;
            r_f_ps2c <= 1'b0;
        end else begin
            r_filter <= {i_ps2c, r_filter[FILTER_LEN-1:1]};
            r_f_ps2c <= w_f_ps2c_next;
        end
    end

    // Hysteresis: keep the previous filtered level until the whole window
    // agrees on a new one.
    always_comb begin
        w_f_ps2c_next = r_f_ps2c;
        if (&r_filter) begin
            w_f_ps2c_next = 1'b1;
        end else if (~|r_filter) begin
            w_f_ps2c_next = 1'b0;
        end
    end

    // Reset leaves the filtered level low, so an idle-high line produces a
    // rising transition after reset but never a falling edge.
    assign o_fall_edge = r_f_ps2c & ~w_f_ps2c_next;

endmodule : ps2_clk_filter
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : Host-side PS/2 receiver. Captures device-to-host frames
//               (start, 8 data LSB first, odd parity, stop) and presents the
//               byte together with parity/framing status on a done tick.
//               Stalled frames are aborted after TIMEOUT_CYC idle cycles.
// Ports       : clk          - system clock
//               reset_n      - asynchronous, active-low reset
//               rx_en        - enables frame start and continuation
//               ps2d         - PS/2 data line (sampled)
//               ps2c         - PS/2 clock line (sampled)
//               rx_idle      - high while waiting for a start bit
//               rx_done_tick - one-cycle pulse when a frame completes
//               dout         - last received byte
//               parity_err   - parity failure of the last frame
//               frame_err    - stop bit was 0 in the last frame
//               timeout_tick - one-cycle pulse on timeout abort
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_en,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       rx_idle,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_tick
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam int SH_W = FRAME_BITS - 1;          // data + parity + stop

    localparam logic [TO_W-1:0] c_to_last  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      c_cnt_load = 4'(FRAME_BITS - 2);

    logic            w_fall_edge;

    ps2_rx_state_t   r_state, w_state_next;
    logic [3:0]      r_bit_cnt, w_bit_cnt_next;
    logic [SH_W-1:0] r_shift, w_shift_next;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_next;
    logic [7:0]      r_dout, w_dout_next;
    logic            r_parity_err, w_parity_err_next;
    logic            r_frame_err, w_frame_err_next;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_ps2c      (ps2c),
        .o_fall_edge (w_fall_edge)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            r_dout       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_to_cnt     <= w_to_cnt_next;
            r_dout       <= w_dout_next;
            r_parity_err <= w_parity_err_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_to_cnt_next     = r_to_cnt;
        w_dout_next       = r_dout;
        w_parity_err_next = r_parity_err;
        w_frame_err_next  = r_frame_err;
        rx_idle           = 1'b0;
        rx_done_tick      = 1'b0;
        timeout_tick      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                rx_idle = 1'b1;
                // A falling edge with ps2d high is not a start bit.
                if (w_fall_edge && rx_en && !ps2d) begin
                    w_bit_cnt_next = c_cnt_load;
                    w_to_cnt_next  = '0;
                    w_state_next   = ST_DPS;
                end
            end

            ST_DPS: begin
                // Abort beats timeout beats a coincident clock edge.
                if (!rx_en) begin
                    w_state_next = ST_IDLE;
                end else if (r_to_cnt == c_to_last) begin
                    timeout_tick = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_fall_edge) begin
                    w_shift_next  = {ps2d, r_shift[SH_W-1:1]};
                    w_to_cnt_next = '0;
                    if (r_bit_cnt == 4'd0) begin
                        w_state_next = ST_LOAD;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt - 4'd1;
                    end
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end

            ST_LOAD: begin
                // Erroneous frames still deliver their byte; the flags tell
                // the consumer whether to trust it.
                w_dout_next       = r_shift[DATA_BITS-1:0];
                w_parity_err_next = odd_parity_error(r_shift[DATA_BITS:0]);
                w_frame_err_next  = ~r_shift[SH_W-1];
                rx_done_tick      = 1'b1;
                w_state_next      = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign dout       = r_dout;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;

endmodule : ps2_rx
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx
// Description : Self-checking bench for ps2_rx. Drives PS/2 frames built from
//               bit lists and compares the receiver outputs against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 10000;
    localparam int HALF        = 40;     // clk cycles per ps2c half period

    logic       clk;
    logic       reset_n;
    logic       rx_en;
    logic       ps2d;
    logic       ps2c;
    logic       rx_idle;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_tick;

    int total;
    int bad;
    int done_cnt;
    int to_cnt;

    // Reference model state: what the outputs should hold right now.
    logic [7:0] m_dout;
    logic       m_par;
    logic       m_frm;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_en        (rx_en),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_idle      (rx_idle),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_tick (timeout_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick counters; the sampled values are the pre-edge outputs.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt <= 0;
            to_cnt   <= 0;
        end else begin
            if (rx_done_tick) done_cnt <= done_cnt + 1;
            if (timeout_tick) to_cnt   <= to_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first n bits of f (f[0] = start) as device-clocked bits.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2d = f[i];
            wait_clk(HALF);
            ps2c = 1'b0;
            wait_clk(HALF);
            ps2c = 1'b1;
        end
        wait_clk(HALF);
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Full frame sent with rx_en high: model updates from the frame contents.
    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic par, input logic stop);
        int d0;
        int t0;
        int ones;
        d0 = done_cnt;
        t0 = to_cnt;
        send_bits(make_frame(d, par, stop), 11);
        ones  = $countones(d) + int'(par);
        m_dout = d;
        m_par  = ((ones % 2) == 0);
        m_frm  = (stop == 1'b0);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_to"},   32'(to_cnt - t0),   32'd0);
        check({tag, "_dout"}, {24'd0, dout},      {24'd0, m_dout});
        check({tag, "_par"},  {31'd0, parity_err}, {31'd0, m_par});
        check({tag, "_frm"},  {31'd0, frame_err},  {31'd0, m_frm});
        check({tag, "_idle"}, {31'd0, rx_idle},    32'd1);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_dout"}, {24'd0, dout},       {24'd0, m_dout});
        check({tag, "_par"},  {31'd0, parity_err}, {31'd0, m_par});
        check({tag, "_frm"},  {31'd0, frame_err},  {31'd0, m_frm});
        check({tag, "_idle"}, {31'd0, rx_idle},    32'd1);
    endtask

    initial begin
        int d0;
        int t0;
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        total   = 0;
        bad     = 0;
        m_dout  = 8'h00;
        m_par   = 1'b0;
        m_frm   = 1'b0;
        reset_n = 1'b0;
        rx_en   = 1'b1;
        ps2d    = 1'b1;
        ps2c    = 1'b1;

        // Reset values.
        wait_clk(3);
        check("rst_idle", {31'd0, rx_idle},      32'd1);
        check("rst_done", {31'd0, rx_done_tick}, 32'd0);
        check("rst_to",   {31'd0, timeout_tick}, 32'd0);
        check("rst_dout", {24'd0, dout},         32'd0);
        check("rst_par",  {31'd0, parity_err},   32'd0);
        check("rst_frm",  {31'd0, frame_err},    32'd0);
        reset_n = 1'b1;
        wait_clk(20);

        // Directed frames.
        frame_and_check("f5a_ok",   8'h5A, 1'b1, 1'b1);
        frame_and_check("f5a_par",  8'h5A, 1'b0, 1'b1);
        frame_and_check("f00_stop", 8'h00, 1'b1, 1'b0);

        // Stalled frame: start + 4 data bits, then ps2c stays high.
        d0 = done_cnt;
        t0 = to_cnt;
        send_bits(make_frame(8'hC3, 1'b1, 1'b1), 5);
        check("stall_busy", {31'd0, rx_idle}, 32'd0);
        wait_clk(TIMEOUT_CYC + 50);
        check("stall_to",   32'(to_cnt - t0),   32'd1);
        check("stall_done", 32'(done_cnt - d0), 32'd0);
        check_held("stall");
        frame_and_check("ff0_after", 8'hF0, 1'b1, 1'b1);

        // Short ps2c glitches in idle, with ps2d low as for a start bit.
        d0 = done_cnt;
        t0 = to_cnt;
        ps2d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2c = 1'b0;
            wait_clk(3);
            ps2c = 1'b1;
            wait_clk(12);
            check("glitch_idle", {31'd0, rx_idle}, 32'd1);
        end
        ps2d = 1'b1;
        wait_clk(20);
        check("glitch_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_to",   32'(to_cnt - t0),   32'd0);
        check_held("glitch");

        // rx_en low for a whole frame.
        d0 = done_cnt;
        rx_en = 1'b0;
        send_bits(make_frame(8'h81, 1'b1, 1'b1), 11);
        check("dis_done", 32'(done_cnt - d0), 32'd0);
        check_held("dis");
        rx_en = 1'b1;
        wait_clk(10);

        // rx_en dropped after the 5th data bit.
        d0 = done_cnt;
        t0 = to_cnt;
        send_bits(make_frame(8'h3C, 1'b1, 1'b1), 6);
        check("abort_busy", {31'd0, rx_idle}, 32'd0);
        rx_en = 1'b0;
        wait_clk(2);
        check("abort_idle", {31'd0, rx_idle}, 32'd1);
        rx_en = 1'b1;
        wait_clk(20);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_to",   32'(to_cnt - t0),   32'd0);
        check_held("abort");

        // Reset pulsed after the 3rd data bit.
        send_bits(make_frame(8'hA7, 1'b0, 1'b1), 4);
        reset_n = 1'b0;
        wait_clk(2);
        m_dout = 8'h00;
        m_par  = 1'b0;
        m_frm  = 1'b0;
        check("mrst_idle", {31'd0, rx_idle},      32'd1);
        check("mrst_done", {31'd0, rx_done_tick}, 32'd0);
        check_held("mrst");
        reset_n = 1'b1;
        wait_clk(20);
        frame_and_check("after_rst", 8'h6B, 1'b0, 1'b1);

        // Random frames with occasional parity and stop errors.
        for (int i = 0; i < 12; i++) begin
            rd = 8'($urandom);
            rp = ($urandom_range(3) == 0) ? (^rd) : ~(^rd);
            rs = ($urandom_range(4) == 0) ? 1'b0 : 1'b1;
            frame_and_check("rand", rd, rp, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_ps2_rx
`default_nettype wire
